// File: rtl/gemm_pkg.sv
// Shared definitions for the GEMM feeder and PE array: feeder states and
// tile geometry / counter-width helpers.
package gemm_pkg;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_READ   = 2'd3
  } state_e;

  function automatic int tile_words(input int n);
    return n * n;
  endfunction

  function automatic int load_cnt_w(input int n);
    return (2 * n * n > 1) ? $clog2(2 * n * n) : 1;
  endfunction

  function automatic int stream_cnt_w(input int n);
    return (n * n > 1) ? $clog2(n * n) : 1;
  endfunction

  function automatic int drain_cnt_w(input int d);
    return (d > 0) ? $clog2(d + 1) : 1;
  endfunction

  // Row-major address of element (row t%n, col t/n): walks a tile column by column.
  function automatic int col_major_addr(input int t, input int n);
    return (t % n) * n + t / n;
  endfunction

endpackage

// File: rtl/gemm_tile_ram.sv
// One tile of operand storage: single write port, registered read port whose
// output is forced to zero in any cycle that was not a read.
module gemm_tile_ram #(
  parameter int C_DATA_WIDTH = 32,
  parameter int C_DEPTH      = 16,
  parameter int C_ADDR_W     = 4
) (
  input  logic                    clock,
  input  logic                    i_reset,
  input  logic                    wr_en,
  input  logic [C_ADDR_W-1:0]     wr_addr,
  input  logic [C_DATA_WIDTH-1:0] wr_data,
  input  logic                    rd_en,
  input  logic [C_ADDR_W-1:0]     rd_addr,
  output logic [C_DATA_WIDTH-1:0] rd_data
);

  logic [C_DATA_WIDTH-1:0] mem [C_DEPTH];
  logic [C_DATA_WIDTH-1:0] rd_data_q;
  logic [C_DATA_WIDTH-1:0] rd_data_d;

  always_comb begin
    rd_data_d = '0;
    if (rd_en) begin
      rd_data_d = mem[rd_addr];
    end
  end

  // Storage is deliberately not reset; only the read register is.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clock) begin
    if (i_reset) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/gemm_feeder.sv
// Loads an A and a B tile from the host, streams A column-major and B row-major
// to the PE chain, waits out the pipeline drain, then pulses the read-out order.
module gemm_feeder
  import gemm_pkg::*;
#(
  parameter int C_DATA_WIDTH   = 32,
  parameter int C_DIM          = 4,
  parameter int C_DRAIN_CYCLES = 8
) (
  input  logic                    clock,
  input  logic                    i_reset,
  input  logic [C_DATA_WIDTH-1:0] s_data,
  input  logic                    s_valid,
  output logic                    s_ready,
  output logic [C_DATA_WIDTH-1:0] Ain_data,
  output logic [C_DATA_WIDTH-1:0] Bin_data,
  output logic                    Ain_valid,
  output logic                    Bin_valid,
  output logic                    o_rd_output,
  output logic                    o_busy
);

  localparam int NN  = tile_words(C_DIM);
  localparam int LCW = load_cnt_w(C_DIM);
  localparam int SCW = stream_cnt_w(C_DIM);
  localparam int DCW = drain_cnt_w(C_DRAIN_CYCLES);

  state_e           state_q, state_d;
  logic [LCW-1:0]   load_cnt_q, load_cnt_d;
  logic [SCW-1:0]   stream_cnt_q, stream_cnt_d;
  logic [DCW-1:0]   drain_cnt_q, drain_cnt_d;
  logic             valid_q, valid_d;
  logic             s_ready_q, s_ready_d;
  logic             busy_q, busy_d;
  logic             rd_output_q, rd_output_d;

  logic             hs;
  logic             a_we, b_we, rd_en;
  logic [SCW-1:0]   a_waddr, b_waddr, a_raddr, b_raddr;

  assign hs = s_valid && s_ready_q;

  always_comb begin
    state_d      = state_q;
    load_cnt_d   = load_cnt_q;
    stream_cnt_d = stream_cnt_q;
    drain_cnt_d  = drain_cnt_q;
    a_we         = 1'b0;
    b_we         = 1'b0;
    rd_en        = 1'b0;
    a_waddr      = SCW'(load_cnt_q);
    b_waddr      = SCW'(load_cnt_q - LCW'(NN));
    a_raddr      = SCW'(col_major_addr(int'(stream_cnt_q), C_DIM));
    b_raddr      = stream_cnt_q;
    unique case (state_q)
      ST_LOAD: begin
        if (hs) begin
          a_we = (load_cnt_q < LCW'(NN));
          b_we = !(load_cnt_q < LCW'(NN));
          if (load_cnt_q == LCW'(2 * NN - 1)) begin
            load_cnt_d = '0;
            state_d    = ST_STREAM;
          end else begin
            load_cnt_d = load_cnt_q + LCW'(1);
          end
        end
      end
      ST_STREAM: begin
        rd_en = 1'b1;
        if (stream_cnt_q == SCW'(NN - 1)) begin
          stream_cnt_d = '0;
          state_d      = ST_DRAIN;
        end else begin
          stream_cnt_d = stream_cnt_q + SCW'(1);
        end
      end
      // The first DRAIN cycle still shows the last valid word, hence D+1 cycles here.
      ST_DRAIN: begin
        if (drain_cnt_q == DCW'(C_DRAIN_CYCLES)) begin
          drain_cnt_d = '0;
          state_d     = ST_READ;
        end else begin
          drain_cnt_d = drain_cnt_q + DCW'(1);
        end
      end
      ST_READ: begin
        state_d = ST_LOAD;
      end
      default: begin
        state_d = ST_LOAD;
      end
    endcase
    valid_d     = rd_en;
    s_ready_d   = (state_d == ST_LOAD);
    busy_d      = (state_d != ST_LOAD);
    rd_output_d = (state_d == ST_READ);
  end

  always_ff @(posedge clock) begin
    if (i_reset) begin
      state_q      <= ST_LOAD;
      load_cnt_q   <= '0;
      stream_cnt_q <= '0;
      drain_cnt_q  <= '0;
      valid_q      <= 1'b0;
      s_ready_q    <= 1'b1;
      busy_q       <= 1'b0;
      rd_output_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      load_cnt_q   <= load_cnt_d;
      stream_cnt_q <= stream_cnt_d;
      drain_cnt_q  <= drain_cnt_d;
      valid_q      <= valid_d;
      s_ready_q    <= s_ready_d;
      busy_q       <= busy_d;
      rd_output_q  <= rd_output_d;
    end
  end

  gemm_tile_ram #(
    .C_DATA_WIDTH(C_DATA_WIDTH),
    .C_DEPTH     (NN),
    .C_ADDR_W    (SCW)
  ) u_ram_a (
    .clock  (clock),
    .i_reset(i_reset),
    .wr_en  (a_we),
    .wr_addr(a_waddr),
    .wr_data(s_data),
    .rd_en  (rd_en),
    .rd_addr(a_raddr),
    .rd_data(Ain_data)
  );

  gemm_tile_ram #(
    .C_DATA_WIDTH(C_DATA_WIDTH),
    .C_DEPTH     (NN),
    .C_ADDR_W    (SCW)
  ) u_ram_b (
    .clock  (clock),
    .i_reset(i_reset),
    .wr_en  (b_we),
    .wr_addr(b_waddr),
    .wr_data(s_data),
    .rd_en  (rd_en),
    .rd_addr(b_raddr),
    .rd_data(Bin_data)
  );

  assign s_ready     = s_ready_q;
  assign Ain_valid   = valid_q;
  assign Bin_valid   = valid_q;
  assign o_rd_output = rd_output_q;
  assign o_busy      = busy_q;

endmodule
